// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed at accept and held in pending registers until the modelled latency expires.
module mdu_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2      = 2 * WIDTH;
    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_latency
        $error("mdu_unit: MUL_CYCLES and DIV_CYCLES must be at least 1");
    end

    logic             busy_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W2-1:0]    pend_q;
    logic             pend_we_q;

    logic [W2-1:0]    pend_d;
    logic             pend_we_d;
    logic [CNT_W-1:0] len_d;
    logic             is_md;
    logic             accept;

    logic [W2-1:0]    acc, ext_sa, ext_sb, ext_ua, ext_ub, prod_s, prod_u;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b, quo_m, rem_m, quo_s, rem_s, quo_u, rem_u;

    assign acc    = {hi_q, lo_q};
    assign ext_sa = {{WIDTH{src_a[WIDTH-1]}}, src_a};
    assign ext_sb = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign ext_ua = {{WIDTH{1'b0}}, src_a};
    assign ext_ub = {{WIDTH{1'b0}}, src_b};
    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    assign prod_s = ext_sa * ext_sb;
    assign prod_u = ext_ua * ext_ub;

    // Signed divide on magnitudes; most-negative / -1 wraps back to most-negative naturally.
    assign neg_a = src_a[WIDTH-1];
    assign neg_b = src_b[WIDTH-1];
    assign mag_a = neg_a ? (~src_a + WIDTH'(1)) : src_a;
    assign mag_b = neg_b ? (~src_b + WIDTH'(1)) : src_b;
    assign quo_m = mag_a / mag_b;
    assign rem_m = mag_a % mag_b;
    assign quo_s = (neg_a ^ neg_b) ? (~quo_m + WIDTH'(1)) : quo_m;
    assign rem_s = neg_a ? (~rem_m + WIDTH'(1)) : rem_m;
    assign quo_u = src_a / src_b;
    assign rem_u = src_a % src_b;

    always_comb begin
        pend_d    = '0;
        pend_we_d = 1'b1;
        len_d     = MUL_N;
        is_md     = 1'b1;
        case (op)
            OP_MULT:  pend_d = prod_s;
            OP_MULTU: pend_d = prod_u;
            OP_MADD:  pend_d = acc + prod_s;
            OP_MADDU: pend_d = acc + prod_u;
            OP_MSUB:  pend_d = acc - prod_s;
            OP_MSUBU: pend_d = acc - prod_u;
            OP_DIV: begin
                pend_d    = {rem_s, quo_s};
                pend_we_d = |src_b;
                len_d     = DIV_N;
            end
            OP_DIVU: begin
                pend_d    = {rem_u, quo_u};
                pend_we_d = |src_b;
                len_d     = DIV_N;
            end
            default: is_md = 1'b0;
        endcase
    end

    assign accept = start && !busy_q && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_we_q <= 1'b0;
        end else if (busy_q) begin
            // Flush takes priority over an expiring count: the result is dropped.
            if (flush) begin
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
                cnt_q     <= '0;
                pend_q    <= '0;
                pend_we_q <= 1'b0;
            end else if (cnt_q == CNT_W'(1)) begin
                if (pend_we_q) begin
                    hi_q <= pend_q[W2-1:WIDTH];
                    lo_q <= pend_q[WIDTH-1:0];
                end
                busy_q <= 1'b0;
                done_q <= 1'b1;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                if (op == OP_MTHI) begin
                    hi_q <= src_a;
                end else if (op == OP_MTLO) begin
                    lo_q <= src_a;
                end else if (is_md) begin
                    pend_q    <= pend_d;
                    pend_we_q <= pend_we_d;
                    cnt_q     <= len_d;
                    busy_q    <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
